// File: rtl/spi_mem_bridge_if.sv
// RAM-port bus between the SPI bridge (master) and one port of the
// dual-port RAM (slave). mem_rdata is combinational from mem_addr.
interface spi_mem_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/spi_mem_bridge.sv
// SPI mode-0 slave that turns serial frames into RAM-port accesses.
// Frame: 8-bit command (0x02 write / 0x03 read), ADDR_WIDTH address bits,
// then any number of DATA_WIDTH-bit words with address auto-increment.
// All SPI pins are oversampled in the clk domain (clk >= 8x sclk).
// The shared rx shift register holds command and address in its low bits,
// so DATA_WIDTH must be >= 8 and >= ADDR_WIDTH.
module spi_mem_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              busy,
    output logic              frame_err,
    spi_mem_bridge_if.master  mem
);

    localparam int CNT_MAX = (DATA_WIDTH > ADDR_WIDTH) ?
                             ((DATA_WIDTH > 8) ? DATA_WIDTH : 8) :
                             ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8);
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_IGNORE
    } state_t;

    // [0] first stage, [1] synchronised, [2] previous synchronised value
    logic [2:0]            sclk_sync_q, sclk_sync_d;
    logic [2:0]            cs_sync_q,   cs_sync_d;
    logic [1:0]            mosi_sync_q, mosi_sync_d;

    state_t                state_q,     state_d;
    logic [CW-1:0]         cnt_q,       cnt_d;
    logic [DATA_WIDTH-1:0] rx_q,        rx_d;
    logic [DATA_WIDTH-1:0] tx_q,        tx_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic                  rd_q,        rd_d;
    logic                  rd_pend_q,   rd_pend_d;
    logic                  mem_en_q,    mem_en_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  frame_err_q, frame_err_d;

    logic                  cs_s, mosi_s;
    logic                  sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [DATA_WIDTH-1:0] rx_next;
    logic                  rd_issue;

    // Synchroniser shift chains and edge detection on the synced copies
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        cs_sync_d   = {cs_sync_q[1:0],   cs_n};
        mosi_sync_d = {mosi_sync_q[0],   mosi};
        cs_s        = cs_sync_q[1];
        mosi_s      = mosi_sync_q[1];
        sclk_rise   =  sclk_sync_q[1] & ~sclk_sync_q[2] & ~cs_s;
        sclk_fall   = ~sclk_sync_q[1] &  sclk_sync_q[2] & ~cs_s;
        cs_fall     = ~cs_sync_q[1] &  cs_sync_q[2];
        cs_rise     =  cs_sync_q[1] & ~cs_sync_q[2];
        rx_next     = {rx_q[DATA_WIDTH-2:0], mosi_s};
    end

    // Frame FSM: field counting, shift registers and RAM-port requests
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        rd_pend_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        frame_err_d = 1'b0;
        rd_issue    = 1'b0;

        if (cs_rise) begin
            // A half-received field is dropped; only an idle read is benign
            state_d = S_IDLE;
            cnt_d   = '0;
            if ((state_q inside {S_CMD, S_ADDR, S_WDATA}) && (cnt_q != '0))
                frame_err_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d = S_CMD;
                        cnt_d   = '0;
                    end
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(7)) begin
                            cnt_d = '0;
                            if (rx_next[7:0] == 8'h02 || rx_next[7:0] == 8'h03) begin
                                state_d = S_ADDR;
                                rd_d    = rx_next[0];
                            end else begin
                                state_d     = S_IGNORE;
                                frame_err_d = 1'b1;
                            end
                        end
                    end
                end
                S_ADDR: begin
                    if (sclk_rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                            cnt_d     = '0;
                            addr_d    = rx_next[ADDR_WIDTH-1:0];
                            state_d   = rd_q ? S_RDATA : S_WDATA;
                            rd_pend_d = rd_q;
                        end
                    end
                end
                S_WDATA: begin
                    if (sclk_rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                            cnt_d       = '0;
                            mem_en_d    = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = addr_q;
                            mem_wdata_d = rx_next;
                            addr_d      = addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_RDATA: begin
                    // Load wins over shift; a fall only shifts once the
                    // current word has started, so a fall that lands
                    // around the load never eats the fresh MSB.
                    if (mem_en_q && !mem_we_q)
                        tx_d = mem.mem_rdata;
                    else if (sclk_fall && cnt_q != '0)
                        tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};

                    if (sclk_rise) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                            // Prefetch so the next MSB is ready before the next rise
                            cnt_d    = '0;
                            rd_issue = 1'b1;
                        end
                    end
                    if (rd_pend_q)
                        rd_issue = 1'b1;

                    if (rd_issue) begin
                        mem_en_d   = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_q;
                        addr_d     = addr_q + ADDR_WIDTH'(1);
                    end
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register; sync flops reset low so a frame already in progress
    // at reset release never looks like a fresh cs_n falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            rd_pend_q   <= rd_pend_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign mem.mem_en    = mem_en_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign frame_err     = frame_err_q;
    assign busy          = (state_q != S_IDLE);
    // Gated by the raw pin so miso drops the instant the master deselects
    assign miso          = ~cs_n & (state_q == S_RDATA) & tx_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: SPI master tasks drive frames, a RAM model
// answers the memory port, and a monitor checks every mem_en pulse
// against a queue of expected accesses pushed by the stimulus.
module tb_spi_mem_bridge;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int HALF = 8;   // clk cycles per sclk half period

    logic clk = 1'b0;
    logic rst_n, sclk, cs_n, mosi;
    logic miso, busy, frame_err;

    spi_mem_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

    spi_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .busy      (busy),
        .frame_err (frame_err),
        .mem       (mif.master)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, synchronous write
    logic [DW-1:0] ram [256];
    assign mif.mem_rdata = ram[mif.mem_addr];
    always @(posedge clk)
        if (mif.mem_en && mif.mem_we)
            ram[mif.mem_addr] <= mif.mem_wdata;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    acc_t exp_q[$];
    acc_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   err_seen = 0;
    logic prev_en = 1'b0;

    // Monitor: every RAM access must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && mif.mem_en) begin
            tests++;
            if (prev_en) begin
                fails++;
                $display("FAIL mem_en_pulse: mem_en high two cycles in a row, required single-cycle");
            end
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_access: we=%0b addr=%02h wdata=%08h, required no access",
                         mif.mem_we, mif.mem_addr, mif.mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mif.mem_we !== mon_e.we || mif.mem_addr !== mon_e.addr ||
                    (mon_e.we && mif.mem_wdata !== mon_e.data)) begin
                    fails++;
                    $display("FAIL access: got we=%0b addr=%02h wdata=%08h, required we=%0b addr=%02h wdata=%08h",
                             mif.mem_we, mif.mem_addr, mif.mem_wdata, mon_e.we, mon_e.addr, mon_e.data);
                end
            end
        end
        if (rst_n && frame_err) err_seen++;
        prev_en = mif.mem_en;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_t e;
        e.we = we; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Mode 0 master: drive mosi while sclk low, sample miso on the rise
    task automatic xfer(input logic [31:0] val, input int n, output logic [31:0] rd);
        rd = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = val[i];
            wclk(HALF);
            sclk = 1'b1;
            rd = {rd[30:0], miso};
            wclk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_lo;
        cs_n = 1'b0;
        wclk(HALF);
    endtask

    task automatic cs_hi;
        wclk(HALF);
        cs_n = 1'b1;
        wclk(12);
    endtask

    task automatic write1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [31:0] rd;
        cs_lo;
        xfer(32'h02, 8, rd);
        xfer({24'h0, a}, 8, rd);
        xfer(d, 32, rd);
        cs_hi;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_en"},    {31'h0, mif.mem_en},    32'h0);
        check({tag, "_mem_we"},    {31'h0, mif.mem_we},    32'h0);
        check({tag, "_mem_addr"},  {24'h0, mif.mem_addr},  32'h0);
        check({tag, "_mem_wdata"}, mif.mem_wdata,          32'h0);
        check({tag, "_miso"},      {31'h0, miso},          32'h0);
        check({tag, "_busy"},      {31'h0, busy},          32'h0);
        check({tag, "_frame_err"}, {31'h0, frame_err},     32'h0);
    endtask

    logic [31:0] rd;

    initial begin
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        wclk(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        wclk(5);

        // Single write
        push(1'b1, 8'h10, 32'hDEADBEEF);
        cs_lo;
        check("busy_in_frame", {31'h0, busy}, 32'h1);
        xfer(32'h02, 8, rd);
        xfer(32'h10, 8, rd);
        xfer(32'hDEADBEEF, 32, rd);
        cs_hi;
        check("busy_after_frame", {31'h0, busy}, 32'h0);
        check("wr_pending", exp_q.size(), 32'h0);
        check("wr_err", err_seen, 32'h0);
        check("wr_ram10", ram[8'h10], 32'hDEADBEEF);

        // Single read; the final rise prefetches 0x11
        push(1'b0, 8'h10, 32'h0);
        push(1'b0, 8'h11, 32'h0);
        cs_lo;
        xfer(32'h03, 8, rd);
        xfer(32'h10, 8, rd);
        xfer(32'h0, 32, rd);
        check("rd_word", rd, 32'hDEADBEEF);
        cs_hi;
        check("rd_pending", exp_q.size(), 32'h0);
        check("miso_cs_high", {31'h0, miso}, 32'h0);

        // Burst write across the address wrap
        push(1'b1, 8'hFF, 32'h11111111);
        push(1'b1, 8'h00, 32'h22222222);
        cs_lo;
        xfer(32'h02, 8, rd);
        xfer(32'hFF, 8, rd);
        xfer(32'h11111111, 32, rd);
        xfer(32'h22222222, 32, rd);
        cs_hi;
        check("wrap_pending", exp_q.size(), 32'h0);
        check("wrap_ramFF", ram[8'hFF], 32'h11111111);
        check("wrap_ram00", ram[8'h00], 32'h22222222);

        // Preload 0x20..0x22, then burst-read them back
        push(1'b1, 8'h20, 32'hA);
        push(1'b1, 8'h21, 32'hB);
        push(1'b1, 8'h22, 32'hC);
        cs_lo;
        xfer(32'h02, 8, rd);
        xfer(32'h20, 8, rd);
        xfer(32'hA, 32, rd);
        xfer(32'hB, 32, rd);
        xfer(32'hC, 32, rd);
        cs_hi;
        for (int i = 0; i < 4; i++) push(1'b0, 8'(8'h20 + i), 32'h0);
        cs_lo;
        xfer(32'h03, 8, rd);
        xfer(32'h20, 8, rd);
        xfer(32'h0, 32, rd); check("burst_rd0", rd, 32'h0000000A);
        xfer(32'h0, 32, rd); check("burst_rd1", rd, 32'h0000000B);
        xfer(32'h0, 32, rd); check("burst_rd2", rd, 32'h0000000C);
        cs_hi;
        check("burst_rd_pending", exp_q.size(), 32'h0);
        check("burst_err", err_seen, 32'h0);

        // Bad command: error after the 8th bit, rest of frame ignored
        cs_lo;
        xfer(32'h55, 8, rd);
        wclk(4);
        check("badcmd_err", err_seen, 32'h1);
        xfer(32'hFF, 8, rd);
        cs_hi;
        check("badcmd_err_once", err_seen, 32'h1);

        // Write aborted after 20 data bits: error, no write
        cs_lo;
        xfer(32'h02, 8, rd);
        xfer(32'h30, 8, rd);
        xfer(32'hABCDE, 20, rd);
        cs_hi;
        check("abort_err", err_seen, 32'h2);
        check("abort_ram30", ram[8'h30], 32'h0);

        // Reset in the middle of the address field
        cs_lo;
        xfer(32'h02, 8, rd);
        xfer(32'h0, 4, rd);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        wclk(3);
        rst_n = 1'b1;
        wclk(2);
        xfer(32'h5, 4, rd);
        xfer(32'hFFF, 12, rd);
        cs_hi;
        check("midrst_tail_err", err_seen, 32'h2);
        push(1'b1, 8'h05, 32'h12345678);
        write1(8'h05, 32'h12345678);
        check("post_rst_ram05", ram[8'h05], 32'h12345678);
        check("post_rst_pending", exp_q.size(), 32'h0);
        check("post_rst_err", err_seen, 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
